// File: rtl/mem_line_responder.sv
// Backing-memory responder for cache refills (burst reads) and word write-throughs, fixed latency.
// Optional feature macro MEM_RESP_ERR_EN: adds resp_err and rejects out-of-range addresses.
module mem_line_responder #(
  parameter int LINE_WORDS  = 4,
  parameter int LATENCY     = 8,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [31:0]                   req_addr,
  input  logic [31:0]                   req_wdata,
  output logic                          resp_valid,
  output logic [31:0]                   resp_data,
  output logic                          resp_last,
  output logic [$clog2(LINE_WORDS)-1:0] resp_idx,
  output logic                          busy
`ifdef MEM_RESP_ERR_EN
  ,
  output logic                          resp_err
`endif
);

  localparam int IDX_W  = $clog2(LINE_WORDS);
  localparam int AW     = $clog2(DEPTH_WORDS);
  localparam int BASE_W = AW - IDX_W;
  localparam int CNT_W  = $clog2(LATENCY + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_ACK} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_write_q, is_write_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic              err_q, err_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic              resp_last_q, resp_last_d;
  logic [IDX_W-1:0]  resp_idx_q, resp_idx_d;
  logic              busy_q, busy_d;

  logic [AW-1:0]     req_word;
  logic              range_err;
  logic              mem_we;
  logic [IDX_W-1:0]  fetch_idx;
  logic [BASE_W-1:0] line_base;
  logic [AW-1:0]     rd_word;
  logic [31:0]       beat_data;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [31:0]       mem_rdata_q;

  assign req_word = req_addr[2 +: AW];

`ifdef MEM_RESP_ERR_EN
  logic unused_addr;
  assign range_err   = (req_addr[31:2] >= 30'(DEPTH_WORDS));
  assign unused_addr = ^req_addr[1:0];
`else
  logic unused_addr;
  assign range_err   = 1'b0;
  assign unused_addr = ^{req_addr[31:2+AW], req_addr[1:0]};
`endif

  assign mem_we = (state_q == S_IDLE) && req_valid && req_write && !range_err;

  // The RAM read is registered, so fetch the word for the beat emitted one edge later.
  always_comb begin
    fetch_idx = '0;
    case (state_q)
      S_WAIT:  fetch_idx = (cnt_q == '0) ? IDX_W'(1) : '0;
      S_BURST: fetch_idx = resp_idx_q + IDX_W'(2);
      default: fetch_idx = '0;
    endcase
  end

  assign line_base = (state_q == S_IDLE) ? req_word[AW-1:IDX_W] : base_q;
  assign rd_word   = {line_base, fetch_idx};
  assign beat_data = err_q ? 32'h0 : mem_rdata_q;

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[req_word] <= req_wdata;
    end
    mem_rdata_q <= mem[rd_word];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_write_d   = is_write_q;
    base_d       = base_q;
    err_d        = err_q;
    resp_valid_d = 1'b0;
    resp_data_d  = 32'h0;
    resp_last_d  = 1'b0;
    resp_idx_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d    = S_WAIT;
          cnt_d      = CNT_W'(LATENCY - 1);
          is_write_d = req_write;
          base_d     = req_word[AW-1:IDX_W];
          err_d      = range_err;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          resp_valid_d = 1'b1;
          if (is_write_q) begin
            state_d     = S_ACK;
            resp_last_d = 1'b1;
          end else begin
            state_d     = S_BURST;
            resp_data_d = beat_data;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_BURST: begin
        if (resp_idx_q == LAST_IDX) begin
          state_d = S_IDLE;
        end else begin
          resp_valid_d = 1'b1;
          resp_idx_d   = resp_idx_q + IDX_W'(1);
          resp_data_d  = beat_data;
          resp_last_d  = (resp_idx_q + IDX_W'(1) == LAST_IDX);
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      is_write_q   <= 1'b0;
      base_q       <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_last_q  <= 1'b0;
      resp_idx_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_write_q   <= is_write_d;
      base_q       <= base_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_last_q  <= resp_last_d;
      resp_idx_q   <= resp_idx_d;
      busy_q       <= busy_d;
    end
  end

`ifdef MEM_RESP_ERR_EN
  logic resp_err_q, resp_err_d;
  assign resp_err_d = resp_valid_d && err_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_err_q <= 1'b0;
    end else begin
      resp_err_q <= resp_err_d;
    end
  end
  assign resp_err = resp_err_q;
`endif

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_last  = resp_last_q;
  assign resp_idx   = resp_idx_q;
  assign busy       = busy_q;

endmodule

// File: doc/mem_line_responder.md
Name: mem_line_responder

Overview:
- Backing-memory responder on the cache-to-main-memory interface; the cache inside the memory subsystem is the initiator.
- Serves line refills (burst reads) and single-word write-throughs, modelling a fixed access latency.
- Lets the cache's miss stall (clock gating of the pipeline) be exercised against realistic timing.
- Runs on the ungated clock, never on the stalled pipeline clock.

Parameters:
LINE_WORDS, 4, words per cache line / refill burst length; power of 2, >=2
LATENCY, 8, cycles between request acceptance and first response beat; >=1
DEPTH_WORDS, 1024, backing storage size in 32-bit words; power of 2

Ports:
clock  input  1  ungated system clock, rising edge
reset  input  1  synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_write  input  1  1 = word write, 0 = line read
req_addr  input  32  byte address
req_wdata  input  32  write data (writes only)
resp_valid  output  1  response beat valid
resp_data  output  32  read data beat; 0 on write ack
resp_last  output  1  final beat of the response
resp_idx  output  log2(LINE_WORDS)  word index of current beat within line
busy  output  1  transaction in progress (not IDLE)

Behaviour:
- Reset: sampled on rising clock edge only. All outputs are forced as follows: req_ready=1, resp_valid=0, resp_last=0, resp_data=0, resp_idx=0, busy=0. The FSM goes to IDLE and counters clear. Storage contents are not cleared.
- Reset mid-transaction aborts it. No further beats are emitted.
- Handshake: request accepted on the edge where req_valid & req_ready. req_ready=1 only in IDLE. The requester holds req_* stable until accepted. Requests while not ready are ignored (no queueing).
- No backpressure on the response side. The initiator must consume one beat per cycle while resp_valid=1.
- Word index into storage = req_addr[2 +: log2(DEPTH_WORDS)]. Upper bits alias (wrap) silently. addr[1:0] is ignored.
- Read: the line base clears the low log2(LINE_WORDS) word bits. Beats go in ascending order, word 0 first, with no critical-word-first.
- Write: data is committed to storage on the acceptance edge, whole word (no byte enables). After the latency, a single ack beat is issued: resp_valid=1, resp_last=1, resp_data=0, resp_idx=0.
- FSM states: IDLE, WAIT, BURST, ACK.
  - IDLE -> WAIT on accept. Latency counter loads LATENCY-1 and the transaction type is latched.
  - WAIT decrements each cycle. At 0: go to BURST if read, or ACK if write.
  - BURST emits one beat per cycle, resp_idx 0..LINE_WORDS-1. resp_last=1 on idx LINE_WORDS-1, then go to IDLE.
  - ACK lasts one cycle, then IDLE.
- Latency: accept at edge t. The first beat is visible in the cycle after edge t+LATENCY. A read occupies LATENCY+LINE_WORDS cycles. req_ready rises in the cycle after the last beat, so back-to-back requests have no extra dead cycle beyond that.
- Read-after-write: a read accepted after a write's ack returns the new data. A write's commit precedes any later read.
- Outputs are registered. resp_data/resp_idx/resp_last are 0 whenever resp_valid=0.

Optional Feature:
- Macro: MEM_RESP_ERR_EN.
- When defined:
  - Extra output resp_err (1 bit, reset 0).
  - A request with req_addr[31:2] >= DEPTH_WORDS is still accepted and timed normally.
  - Reads return resp_data=0 with resp_err=1 on every beat.
  - Writes are discarded and the ack carries resp_err=1.
- When undefined: no resp_err port, and out-of-range addresses alias via wrap as above.

Test Plan:
- Parameters used unless noted: LATENCY=3, LINE_WORDS=4.
- After reset, write 0xDEADBEEF to 0x40, await ack, then read 0x44 -> beats idx0..3 = 0xDEADBEEF,x,x,x from words 0x40..0x4C; resp_last only on idx3; first beat 3 cycles after accept.
- Preload 0x100..0x10C with 1,2,3,4 via writes, then read 0x108 -> line base 0x100, beats 1,2,3,4 in order; req_ready=0 for 7 cycles, then 1.
- Hold req_valid=1 during a burst with another address -> ignored until req_ready=1, then accepted the next edge; exactly one extra transaction.
- Assert reset during the WAIT of a read -> next cycle req_ready=1, resp_valid=0, busy=0, no beats; a later read of a previously written word still returns its data.
- Address wrap (DEPTH_WORDS=1024): write 0x55 to 0x1000, then read 0x0 -> beat 0 = 0x55.
- With MEM_RESP_ERR_EN and DEPTH_WORDS=1024: read 0x1000 -> 4 beats of 0 with resp_err=1; write to 0x2000 -> ack with resp_err=1 and word 0 unchanged.
